// File: rtl/qeg_pkg.sv
// Shared types and Gray-step tables for the quadrature encoder emulator.
package qeg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } qeg_state_e;

   // Next {B,A} code, indexed by the current {B,A} code.
   localparam logic [1:0] GRAY_FWD_NEXT [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
   localparam logic [1:0] GRAY_REV_NEXT [4] = '{2'b10, 2'b00, 2'b11, 2'b01};

   // |cmd| as unsigned; -2^31 maps to 2^31.
   function automatic logic [31:0] cmd_magnitude(input logic [31:0] cmd);
      return cmd[31] ? (~cmd + 32'd1) : cmd;
   endfunction

endpackage

// File: rtl/qeg_rate_tick.sv
// Edge-rate prescaler: counts 0..P-1 while enabled and fires a 1-cycle tick at P-1.
module qeg_rate_tick #(
   parameter int PERIOD_W = 16
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic                en,
   input  logic                restart,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

   logic [PERIOD_W-1:0] count_q, count_d;

   // A restart (new LOAD) suppresses any tick in the same cycle.
   always_comb begin
      tick    = en && !restart && (count_q == (period - ONE));
      count_d = count_q + ONE;
      if (restart || !en || tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/qei_pulse_gen.sv
// Quadrature encoder emulator: signed step command -> Gray-coded PHASEA/PHASEB.
// Optional index output and angle counter are built when QEG_INDEX_EN is defined.
//
// state | meaning
// IDLE  | no run in progress, phases hold
// RUN   | emitting one edge per tick until REMAIN reaches 0
// DONE  | run completed; QEG_DONE pulses on the following cycle
module qei_pulse_gen
   import qeg_pkg::*;
#(
   parameter int PERIOD_W   = 16,
   parameter int MIN_PERIOD = 2,
   parameter int CPR        = 1024
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic [31:0]         QEG_CMD_Set,
   input  logic                QEG_LOAD,
   input  logic                QEG_STOP,
   input  logic                QEG_CLEAR,
   input  logic [PERIOD_W-1:0] QEG_PERIOD_Set,
   output logic [31:0]         QEG_POS_Read,
   output logic [31:0]         QEG_REMAIN_Read,
   output logic                QEG_BUSY,
   output logic                QEG_DONE,
   output logic                CH_PHASEA,
   output logic                CH_PHASEB
`ifdef QEG_INDEX_EN
   ,
   output logic                CH_INDEX
`endif
);

   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

   qeg_state_e          state_q, state_d;
   logic [31:0]         remain_q, remain_d;
   logic                dir_q, dir_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [31:0]         pos_q, pos_d;
   logic [1:0]          ph_q, ph_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                load_ok;
   logic                restart;
   logic                tick;
   logic                tick_en;
   logic [31:0]         cmd_mag;
   logic [PERIOD_W-1:0] period_clamped;

   assign load_ok        = QEG_LOAD && !QEG_STOP;
   assign cmd_mag        = cmd_magnitude(QEG_CMD_Set);
   assign period_clamped = (QEG_PERIOD_Set < MIN_P) ? MIN_P : QEG_PERIOD_Set;
   assign tick_en        = (state_q == RUN) && !QEG_STOP;
   assign restart        = load_ok;

   qeg_rate_tick #(
      .PERIOD_W (PERIOD_W)
   ) u_rate_tick (
      .CLK     (CLK),
      .RST_n   (RST_n),
      .en      (tick_en),
      .restart (restart),
      .period  (period_q),
      .tick    (tick)
   );

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      dir_d    = dir_q;
      period_d = period_q;

      case (state_q)
         RUN: begin
            if (QEG_STOP) begin
               state_d  = IDLE;
               remain_d = '0;
            end else if (tick) begin
               remain_d = remain_q - 32'd1;
               if (remain_q == 32'd1) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A LOAD is accepted identically from IDLE, DONE or RUN (retarget).
      if (load_ok) begin
         period_d = period_clamped;
         dir_d    = QEG_CMD_Set[31];
         remain_d = cmd_mag;
         state_d  = (cmd_mag != 32'd0) ? RUN : DONE;
      end
   end

   always_comb begin
      ph_d  = ph_q;
      pos_d = pos_q;
      if (tick) begin
         ph_d  = dir_q ? GRAY_REV_NEXT[ph_q] : GRAY_FWD_NEXT[ph_q];
         pos_d = dir_q ? (pos_q - 32'd1) : (pos_q + 32'd1);
      end
      if (QEG_CLEAR) begin
         pos_d = '0;
      end
      busy_d = (state_d == RUN);
      done_d = (state_q == DONE);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q  <= IDLE;
         remain_q <= '0;
         dir_q    <= 1'b0;
         period_q <= MIN_P;
         pos_q    <= '0;
         ph_q     <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         dir_q    <= dir_d;
         period_q <= period_d;
         pos_q    <= pos_d;
         ph_q     <= ph_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign QEG_POS_Read    = pos_q;
   assign QEG_REMAIN_Read = remain_q;
   assign QEG_BUSY        = busy_q;
   assign QEG_DONE        = done_q;
   assign CH_PHASEA       = ph_q[0];
   assign CH_PHASEB       = ph_q[1];

`ifdef QEG_INDEX_EN
   localparam int ANG_W = $clog2(4 * CPR);
   localparam logic [ANG_W-1:0] ANG_MAX = ANG_W'(4 * CPR - 1);

   logic [ANG_W-1:0] angle_q, angle_d;
   logic             index_q, index_d;

   // Angle tracks the phase modulo one revolution, so angle 0 lands on {B,A}=00.
   always_comb begin
      angle_d = angle_q;
      if (tick) begin
         if (dir_q) begin
            angle_d = (angle_q == '0) ? ANG_MAX : (angle_q - ANG_W'(1));
         end else begin
            angle_d = (angle_q == ANG_MAX) ? '0 : (angle_q + ANG_W'(1));
         end
      end
      if (QEG_CLEAR) begin
         angle_d = '0;
      end
      index_d = (angle_d == '0);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         angle_q <= '0;
         index_q <= 1'b1;
      end else begin
         angle_q <= angle_d;
         index_q <= index_d;
      end
   end

   assign CH_INDEX = index_q;
`endif

endmodule

// File: tb/tb_qei_pulse_gen.sv
// Scoreboard bench for qei_pulse_gen: stimulus queues expected edges/DONE pulses, a monitor checks them.
module tb_qei_pulse_gen;

   localparam int PW = 16;

   logic          CLK = 1'b0;
   logic          RST_n = 1'b0;
   logic [31:0]   QEG_CMD_Set = '0;
   logic          QEG_LOAD = 1'b0;
   logic          QEG_STOP = 1'b0;
   logic          QEG_CLEAR = 1'b0;
   logic [PW-1:0] QEG_PERIOD_Set = '0;
   logic [31:0]   QEG_POS_Read;
   logic [31:0]   QEG_REMAIN_Read;
   logic          QEG_BUSY;
   logic          QEG_DONE;
   logic          CH_PHASEA;
   logic          CH_PHASEB;
`ifdef QEG_INDEX_EN
   logic          CH_INDEX;
`endif

   qei_pulse_gen #(
      .PERIOD_W   (PW),
      .MIN_PERIOD (2),
      .CPR        (2)
   ) dut (
      .CLK             (CLK),
      .RST_n           (RST_n),
      .QEG_CMD_Set     (QEG_CMD_Set),
      .QEG_LOAD        (QEG_LOAD),
      .QEG_STOP        (QEG_STOP),
      .QEG_CLEAR       (QEG_CLEAR),
      .QEG_PERIOD_Set  (QEG_PERIOD_Set),
      .QEG_POS_Read    (QEG_POS_Read),
      .QEG_REMAIN_Read (QEG_REMAIN_Read),
      .QEG_BUSY        (QEG_BUSY),
      .QEG_DONE        (QEG_DONE),
      .CH_PHASEA       (CH_PHASEA),
      .CH_PHASEB       (CH_PHASEB)
`ifdef QEG_INDEX_EN
      ,
      .CH_INDEX        (CH_INDEX)
`endif
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      bit          is_done;
      int          cyc;
      logic [1:0]  ba;
      logic [31:0] pos;
   } ev_t;

   ev_t sb[$];
   ev_t mon_e;

   int checks = 0;
   int errors = 0;

   // Reference model: position count and quadrature index 0..3 walked around the Gray cycle.
   logic [1:0]  gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   logic [31:0] m_pos = '0;
   int          m_q = 0;

   bit          mon_en = 1'b0;
   logic [1:0]  prev_ba = 2'b00;
   logic [31:0] dec_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int qidx(input logic [1:0] ba);
      for (int i = 0; i < 4; i++) begin
         if (gray_tab[i] == ba) return i;
      end
      return 0;
   endfunction

   // Monitor plus loopback quadrature decoder.
   always @(negedge CLK) begin
      if (RST_n && mon_en) begin
         if ({CH_PHASEB, CH_PHASEA} != prev_ba) begin
            case ((qidx({CH_PHASEB, CH_PHASEA}) - qidx(prev_ba) + 4) % 4)
               1:       dec_cnt = dec_cnt + 32'd1;
               3:       dec_cnt = dec_cnt - 32'd1;
               default: ;
            endcase
            if (sb.size() == 0 || sb[0].is_done) begin
               checks++;
               errors++;
               $display("FAIL unexpected_edge at cycle %0d: actual ba=%b required=no edge", cyc, {CH_PHASEB, CH_PHASEA});
            end else begin
               mon_e = sb.pop_front();
               check("edge_cycle", 32'(cyc), 32'(mon_e.cyc));
               check("edge_ba", {30'd0, CH_PHASEB, CH_PHASEA}, {30'd0, mon_e.ba});
               check("edge_pos", QEG_POS_Read, mon_e.pos);
            end
         end
         if (QEG_DONE) begin
            if (sb.size() == 0 || !sb[0].is_done) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done at cycle %0d: actual done=1 required done=0", cyc);
            end else begin
               mon_e = sb.pop_front();
               check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
         end
         if (QEG_CLEAR) dec_cnt = '0;
      end
      prev_ba = {CH_PHASEB, CH_PHASEA};
   end

   // Issue a LOAD and queue the expected response. limit<0: whole run plus DONE; else only the first 'limit' edges.
   task automatic load_cmd(input logic [31:0] cmd, input int per, input int limit, output int l_cyc);
      longint mag;
      longint n_push;
      int     p;
      @(negedge CLK);
      QEG_CMD_Set    = cmd;
      QEG_PERIOD_Set = PW'(per);
      QEG_LOAD       = 1'b1;
      l_cyc  = cyc + 1;
      p      = (per < 2) ? 2 : per;
      mag    = cmd[31] ? -longint'($signed(cmd)) : longint'(cmd);
      n_push = (limit < 0) ? mag : longint'(limit);
      for (longint k = 1; k <= n_push; k++) begin
         m_q   = cmd[31] ? (m_q + 3) % 4 : (m_q + 1) % 4;
         m_pos = cmd[31] ? m_pos - 32'd1 : m_pos + 32'd1;
         sb.push_back('{is_done: 1'b0, cyc: l_cyc + int'(k) * p, ba: gray_tab[m_q], pos: m_pos});
      end
      if (limit < 0) begin
         sb.push_back('{is_done: 1'b1, cyc: l_cyc + int'(mag) * p + 1, ba: 2'b00, pos: m_pos});
      end
      @(negedge CLK);
      QEG_LOAD = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (sb.size() != 0 || QEG_BUSY); i++) @(negedge CLK);
      checks++;
      if (sb.size() != 0 || QEG_BUSY) begin
         errors++;
         $display("FAIL drain_timeout: actual pending=%0d busy=%b required pending=0 busy=0", sb.size(), QEG_BUSY);
         sb.delete();
      end
      repeat (2) @(negedge CLK);
   endtask

   task automatic wait_cyc(input int target);
      for (int i = 0; i < 5000 && cyc < target; i++) @(negedge CLK);
   endtask

   task automatic clear_pos();
      @(negedge CLK);
      QEG_CLEAR = 1'b1;
      @(negedge CLK);
      QEG_CLEAR = 1'b0;
      m_pos = '0;
      check("clear_pos", QEG_POS_Read, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int l_cyc;
      int l2;
      int cmd_i;
      logic [31:0] pos_hold;

      repeat (3) @(negedge CLK);
      check("rst_pos", QEG_POS_Read, 32'd0);
      check("rst_remain", QEG_REMAIN_Read, 32'd0);
      check("rst_flags", {28'd0, QEG_BUSY, QEG_DONE, CH_PHASEB, CH_PHASEA}, 32'd0);
      RST_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge CLK);

      // Forward run +8 at period 4.
      load_cmd(32'd8, 4, -1, l_cyc);
      check("fwd_busy", {31'd0, QEG_BUSY}, 32'd1);
      drain(200);
      check("fwd_pos", QEG_POS_Read, 32'd8);
      check("fwd_decoder", dec_cnt, 32'd8);
      check("fwd_remain", QEG_REMAIN_Read, 32'd0);

      // Reverse run -5 with period clamped from 0 to 2.
      clear_pos();
      load_cmd(-32'sd5, 0, -1, l_cyc);
      drain(200);
      check("rev_pos", QEG_POS_Read, 32'hFFFF_FFFB);
      check("rev_decoder", dec_cnt, 32'hFFFF_FFFB);

      // Retarget +100 -> -3 after 10 edges.
      clear_pos();
      load_cmd(32'd100, 3, 10, l_cyc);
      wait_cyc(l_cyc + 30);
      load_cmd(-32'sd3, 3, -1, l2);
      drain(200);
      check("retarget_pos", QEG_POS_Read, 32'd7);

      // STOP and LOAD together mid-run: STOP wins.
      load_cmd(32'd20, 3, 2, l_cyc);
      wait_cyc(l_cyc + 6);
      @(negedge CLK);
      QEG_STOP    = 1'b1;
      QEG_LOAD    = 1'b1;
      QEG_CMD_Set = 32'd50;
      @(negedge CLK);
      QEG_STOP = 1'b0;
      QEG_LOAD = 1'b0;
      check("stop_busy", {31'd0, QEG_BUSY}, 32'd0);
      check("stop_remain", QEG_REMAIN_Read, 32'd0);
      pos_hold = m_pos;
      repeat (12) @(negedge CLK);
      check("stop_pos_hold", QEG_POS_Read, pos_hold);
      check("stop_queue_empty", 32'(sb.size()), 32'd0);

      // Zero command: DONE pulse only.
      load_cmd(32'd0, 5, -1, l_cyc);
      drain(50);

      // Magnitude of -2^31 is 2^31.
      load_cmd(32'h8000_0000, 7, 0, l_cyc);
      check("min_int_remain", QEG_REMAIN_Read, 32'h8000_0000);
      QEG_STOP = 1'b1;
      @(negedge CLK);
      QEG_STOP = 1'b0;
      check("min_int_stop_remain", QEG_REMAIN_Read, 32'd0);

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         cmd_i = int'($urandom_range(0, 24)) - 12;
         load_cmd(32'(cmd_i), int'($urandom_range(0, 5)), -1, l_cyc);
         drain(400);
         check("rand_pos", QEG_POS_Read, m_pos);
         check("rand_decoder", dec_cnt, m_pos);
      end

`ifdef QEG_INDEX_EN
      if (m_q != 0) begin
         load_cmd(32'((4 - m_q) % 4), 2, -1, l_cyc);
         drain(100);
      end
      clear_pos();
      @(negedge CLK);
      check("index_after_clear", {31'd0, CH_INDEX}, 32'd1);
      load_cmd(32'd16, 2, -1, l_cyc);
      drain(200);
      check("index_at_16", {31'd0, CH_INDEX}, 32'd1);
      load_cmd(-32'sd3, 2, -1, l_cyc);
      drain(100);
      check("index_off", {31'd0, CH_INDEX}, 32'd0);
      load_cmd(-32'sd5, 2, -1, l_cyc);
      drain(100);
      check("index_back", {31'd0, CH_INDEX}, 32'd1);
`endif

      // Asynchronous reset in the middle of a run.
      load_cmd(32'd50, 4, 3, l_cyc);
      wait_cyc(l_cyc + 13);
      mon_en = 1'b0;
      #2;
      RST_n = 1'b0;
      #1;
      check("midrun_rst_pos", QEG_POS_Read, 32'd0);
      check("midrun_rst_remain", QEG_REMAIN_Read, 32'd0);
      check("midrun_rst_flags", {28'd0, QEG_BUSY, QEG_DONE, CH_PHASEB, CH_PHASEA}, 32'd0);
      check("final_queue_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
